// File: rtl/jmp_pkg.sv
// Shared definitions for the jrb8 sequential jump unit: condition codes,
// operation modes, FSM states and the flag-condition evaluator.
package jmp_pkg;

  localparam logic [3:0] CC_ALWAYS = 4'd0;
  localparam logic [3:0] CC_EQ     = 4'd1;
  localparam logic [3:0] CC_NE     = 4'd2;
  localparam logic [3:0] CC_LTU    = 4'd3;
  localparam logic [3:0] CC_GEU    = 4'd4;
  localparam logic [3:0] CC_LT     = 4'd5;
  localparam logic [3:0] CC_GE     = 4'd6;
  localparam logic [3:0] CC_LE     = 4'd7;
  localparam logic [3:0] CC_GT     = 4'd8;
  localparam logic [3:0] CC_NEG    = 4'd9;
  localparam logic [3:0] CC_OVF    = 4'd10;

  typedef enum logic [1:0] {
    MODE_ABS  = 2'd0,
    MODE_REL  = 2'd1,
    MODE_CALL = 2'd2,
    MODE_RET  = 2'd3
  } mode_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_EXEC  = 2'd2
  } state_t;

  // Codes 11-15 fall through to "never".
  function automatic logic cond_eval(input logic [3:0] cc, input logic z, input logic o,
                                     input logic c, input logic s);
    logic lt;
    lt = s ^ o;
    case (cc)
      CC_ALWAYS: cond_eval = 1'b1;
      CC_EQ:     cond_eval = z;
      CC_NE:     cond_eval = !z;
      CC_LTU:    cond_eval = c;
      CC_GEU:    cond_eval = !c;
      CC_LT:     cond_eval = lt;
      CC_GE:     cond_eval = !lt;
      CC_LE:     cond_eval = lt | z;
      CC_GT:     cond_eval = !(lt | z);
      CC_NEG:    cond_eval = s;
      CC_OVF:    cond_eval = o;
      default:   cond_eval = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/jmp_stack.sv
// Small LIFO holding call return addresses; push and pop are never requested together.
module jmp_stack #(
  parameter int W     = 16,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic         full,
  output logic         empty,
  output logic [W-1:0] top
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [CW-1:0] cnt_q, cnt_d;
  logic [IW-1:0] wr_idx, rd_idx;

  always_comb begin
    wr_idx = IW'(cnt_q);
    rd_idx = IW'(cnt_q - CW'(1));
    full   = (cnt_q == CW'(DEPTH));
    empty  = (cnt_q == '0);
    top    = mem_q[rd_idx];
    cnt_d  = cnt_q;
    if (push && !full)       cnt_d = cnt_q + CW'(1);
    else if (pop && !empty)  cnt_d = cnt_q - CW'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  // Entry storage needs no reset: the count alone defines what is valid.
  always_ff @(posedge clk) begin
    if (push && !full) mem_q[wr_idx] <= din;
  end

endmodule

// File: rtl/jmp_seq.sv
// Sequential jump/branch unit: fetches multi-byte targets from the bus, evaluates
// flag conditions, handles PC-relative branches and call/return via jmp_stack.
module jmp_seq
  import jmp_pkg::*;
#(
  parameter int DATA_W      = 8,
  parameter int ADDR_W      = 16,
  parameter int STACK_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [7:0]        jmpins,
  input  logic [DATA_W-1:0] databus,
  input  logic              bus_valid,
  input  logic [ADDR_W-1:0] pcin,
  input  logic              zin,
  input  logic              oin,
  input  logic              cin,
  input  logic              sin,
  output logic              pcoe,
  output logic [ADDR_W-1:0] pcout,
  output logic              busy,
  output logic              stk_err,
  output logic [1:0]        state_dbg
);

  localparam int NB = (ADDR_W + DATA_W - 1) / DATA_W;
  localparam int TW = NB * DATA_W;
  localparam int CW = $clog2(NB + 1);

  state_t              state_q, state_d;
  mode_t               mode_q, mode_d;
  logic                taken_q, taken_d;
  logic [ADDR_W-1:0]   pcin_q, pcin_d;
  logic [TW-1:0]       tgt_q, tgt_d;
  logic [CW-1:0]       cnt_q, cnt_d, need;
  logic [ADDR_W-1:0]   pcout_q, pcout_d;
  logic                pcoe_q, pcoe_d;
  logic                stk_err_q, stk_err_d;
  logic                push, pop, full, empty;
  logic [ADDR_W-1:0]   stk_top, abs_tgt, rel_tgt;
  logic signed [ADDR_W-1:0] rel_off;

  jmp_stack #(.W(ADDR_W), .DEPTH(STACK_DEPTH)) u_stack (
    .clk   (clk),
    .rst   (reset),
    .push  (push),
    .pop   (pop),
    .din   (pcin_q),
    .full  (full),
    .empty (empty),
    .top   (stk_top)
  );

  always_comb begin
    need    = (mode_q == MODE_REL) ? CW'(1) : CW'(NB);
    abs_tgt = tgt_q[ADDR_W-1:0];
    rel_off = ADDR_W'($signed(tgt_q[DATA_W-1:0]));
    rel_tgt = pcin_q + rel_off;

    state_d   = state_q;
    mode_d    = mode_q;
    taken_d   = taken_q;
    pcin_d    = pcin_q;
    tgt_d     = tgt_q;
    cnt_d     = cnt_q;
    pcout_d   = pcout_q;
    pcoe_d    = 1'b0;
    stk_err_d = stk_err_q;
    push      = 1'b0;
    pop       = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          mode_d  = mode_t'(jmpins[5:4]);
          taken_d = (jmpins[7:6] == 2'b00) && cond_eval(jmpins[3:0], zin, oin, cin, sin);
          pcin_d  = pcin;
          tgt_d   = '0;
          cnt_d   = '0;
          state_d = (jmpins[5:4] == MODE_RET) ? ST_EXEC : ST_FETCH;
        end
      end
      ST_FETCH: begin
        // Bytes arrive LSB first; a stalled bus just holds this state.
        if (bus_valid) begin
          tgt_d[int'(cnt_q) * DATA_W +: DATA_W] = databus;
          cnt_d = cnt_q + CW'(1);
          if (cnt_d == need) state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        state_d = ST_IDLE;
        if (taken_q) begin
          case (mode_q)
            MODE_RET: begin
              if (empty) begin
                stk_err_d = 1'b1;
              end else begin
                pop     = 1'b1;
                pcout_d = stk_top;
                pcoe_d  = 1'b1;
              end
            end
            MODE_CALL: begin
              // A full stack loses the return address but the jump still happens.
              if (full) stk_err_d = 1'b1;
              else      push      = 1'b1;
              pcout_d = abs_tgt;
              pcoe_d  = 1'b1;
            end
            MODE_REL: begin
              pcout_d = rel_tgt;
              pcoe_d  = 1'b1;
            end
            default: begin
              pcout_d = abs_tgt;
              pcoe_d  = 1'b1;
            end
          endcase
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      mode_q    <= MODE_ABS;
      taken_q   <= 1'b0;
      pcin_q    <= '0;
      tgt_q     <= '0;
      cnt_q     <= '0;
      pcout_q   <= '0;
      pcoe_q    <= 1'b0;
      stk_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      mode_q    <= mode_d;
      taken_q   <= taken_d;
      pcin_q    <= pcin_d;
      tgt_q     <= tgt_d;
      cnt_q     <= cnt_d;
      pcout_q   <= pcout_d;
      pcoe_q    <= pcoe_d;
      stk_err_q <= stk_err_d;
    end
  end

  assign pcout     = pcout_q;
  assign pcoe      = pcoe_q;
  assign stk_err   = stk_err_q;
  assign busy      = (state_q != ST_IDLE);
  assign state_dbg = state_q;

endmodule
